// File: rtl/prio_enc_queue.sv
// ---------------------------------------------------------------------------
// prio_enc_queue
//
// Registered priority-encoder queue. Request bits are latched into a sticky
// pending vector; one encoded index at a time is presented on a valid/ready
// output and cleared from the pending vector when the consumer accepts it.
// Every request is therefore serviced eventually, not only the highest one.
//
// Parameters:
//   WIDTH      number of request lines (2..64)
//   OUT_W      width of out_code, must be >= $clog2(WIDTH)
//   IDLE_CODE  out_code value while nothing is pending; it is truncated or
//              zero-extended to OUT_W
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (clears pending and ptr)
//   req_in     request lines; bit i set => request i pending from next cycle
//   flush      drop all pending requests; requests arriving this cycle stay
//   rr_mode    0 = fixed priority (MSB highest), 1 = round-robin
//   out_valid  a pending request is presented
//   out_ready  consumer accepts the presented index this cycle
//   out_code   index of the presented request, or IDLE_CODE when idle
//   pend_cnt   population count of the pending vector
//
// Build option:
//   PRIO_ENC_RR_EN  when defined, rr_mode is honoured and the round-robin
//                   pointer is built. When undefined, rr_mode is ignored and
//                   selection is always fixed priority. Ports are identical
//                   in both builds.
// ---------------------------------------------------------------------------
module prio_enc_queue #(
    parameter int         WIDTH     = 16,
    parameter int         OUT_W     = 8,
    parameter logic [7:0] IDLE_CODE = 8'hF0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           req_in,
    input  logic                       flush,
    input  logic                       rr_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_code,
    output logic [$clog2(WIDTH+1)-1:0] pend_cnt
);

    localparam int SEL_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH+1);

    // Pad IDLE_CODE on the left so both truncation and zero-extension to
    // OUT_W come out of one slice.
    localparam logic [OUT_W+7:0] IDLE_WIDE = {{OUT_W{1'b0}}, IDLE_CODE};
    localparam logic [OUT_W-1:0] IDLE_OUT  = IDLE_WIDE[OUT_W-1:0];

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] clr;
    logic [SEL_W-1:0] fixed_sel;
    logic [SEL_W-1:0] sel;
    logic             accept;

    // Selection only ever looks at registered state, so req_in reaches
    // out_valid with exactly one cycle of latency.
    assign out_valid = |pending_q;

    // A flush cycle discards any accept: neither the clear nor the pointer
    // update takes effect.
    assign accept = out_valid & out_ready & ~flush;

    // Fixed priority: highest set index wins (the last hit in an ascending
    // scan overwrites the earlier ones).
    always_comb begin
        fixed_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
                fixed_sel = SEL_W'(i);
            end
        end
    end

`ifdef PRIO_ENC_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] rr_sel;

    // Round-robin: start one below the last accepted index (WIDTH-1 when
    // ptr is 0), scan downward and wrap from 0 to WIDTH-1. The first set bit
    // found is chosen, so the last winner becomes the lowest priority.
    always_comb begin
        int               start;
        int               idx;
        logic [SEL_W-1:0] idx_v;
        logic             found;
        rr_sel = '0;
        found  = 1'b0;
        idx    = 0;
        idx_v  = '0;
        start  = (ptr_q == '0) ? (WIDTH - 1) : (int'(ptr_q) - 1);
        for (int k = 0; k < WIDTH; k++) begin
            idx = start - k;
            if (idx < 0) begin
                idx = idx + WIDTH;
            end
            idx_v = SEL_W'(idx);
            if (!found && pending_q[idx_v]) begin
                rr_sel = idx_v;
                found  = 1'b1;
            end
        end
    end

    // The pointer tracks the accepted index in both modes, so switching
    // modes mid-stream continues from the most recent winner.
    always_comb begin
        sel   = rr_mode ? rr_sel : fixed_sel;
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed-priority-only build: rr_mode stays on the port list but has no
    // function.
    logic rr_mode_unused;
    assign rr_mode_unused = rr_mode;

    always_comb begin
        sel = fixed_sel;
    end
`endif

    // Pending update. A new request on the bit being cleared wins because
    // req_in is OR-ed in after the clear.
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[sel] = 1'b1;
        end
        if (flush) begin
            pending_d = req_in;
        end else begin
            pending_d = (pending_q & ~clr) | req_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        out_code = out_valid ? OUT_W'(sel) : IDLE_OUT;
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_cnt = pend_cnt + CNT_W'(pending_q[i]);
        end
    end

endmodule

// File: tb/tb_prio_enc_queue.sv
module tb_prio_enc_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_in;
    logic        flush;
    logic        rr_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_code;
    logic [4:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    prio_enc_queue #(.WIDTH(16), .OUT_W(8), .IDLE_CODE(8'hF0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .flush     (flush),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] req;
        logic        flush;
        logic        ready;
        logic        exp_v;
        logic [7:0]  exp_code;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
    task automatic step(input logic r, input logic [15:0] rq, input logic fl, input logic rdy);
        rst       = r;
        req_in    = rq;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] c, input logic [4:0] n);
        chk({name, ".valid"}, 32'(out_valid), 32'(v));
        chk({name, ".code"},  32'(out_code),  32'(c));
        chk({name, ".cnt"},   32'(pend_cnt),  32'(n));
    endtask

    initial begin
        //            name        rst  req       fl  rdy  v  code   cnt
        vecs.push_back('{"rst0",   1, 16'hFFFF, 0, 0, 0, 8'hF0, 5'd0});
        vecs.push_back('{"rst1",   1, 16'hFFFF, 0, 0, 0, 8'hF0, 5'd0});
        vecs.push_back('{"rstrel", 0, 16'hFFFF, 0, 0, 1, 8'd15, 5'd16});
        vecs.push_back('{"clr",    0, 16'h0000, 1, 0, 0, 8'hF0, 5'd0});
        // fixed-priority drain of 8421
        vecs.push_back('{"drn0",   0, 16'h8421, 0, 1, 1, 8'd15, 5'd4});
        vecs.push_back('{"drn1",   0, 16'h0000, 0, 1, 1, 8'd10, 5'd3});
        vecs.push_back('{"drn2",   0, 16'h0000, 0, 1, 1, 8'd5,  5'd2});
        vecs.push_back('{"drn3",   0, 16'h0000, 0, 1, 1, 8'd0,  5'd1});
        vecs.push_back('{"drn4",   0, 16'h0000, 0, 1, 0, 8'hF0, 5'd0});
        // back-pressure then pre-emption by bit 12
        vecs.push_back('{"bp0",    0, 16'h0008, 0, 0, 1, 8'd3,  5'd1});
        vecs.push_back('{"bp1",    0, 16'h0000, 0, 0, 1, 8'd3,  5'd1});
        vecs.push_back('{"bp2",    0, 16'h0000, 0, 0, 1, 8'd3,  5'd1});
        vecs.push_back('{"bp3",    0, 16'h0000, 0, 0, 1, 8'd3,  5'd1});
        vecs.push_back('{"pre",    0, 16'h1000, 0, 0, 1, 8'd12, 5'd2});
        vecs.push_back('{"pre1",   0, 16'h0000, 0, 1, 1, 8'd3,  5'd1});
        vecs.push_back('{"pre2",   0, 16'h0000, 0, 1, 0, 8'hF0, 5'd0});
        // clear/set collision on bit 7
        vecs.push_back('{"col0",   0, 16'h0080, 0, 0, 1, 8'd7,  5'd1});
        vecs.push_back('{"col1",   0, 16'h0080, 0, 1, 1, 8'd7,  5'd1});
        vecs.push_back('{"col2",   0, 16'h0000, 0, 1, 0, 8'hF0, 5'd0});
        // flush keeps same-cycle requests and suppresses the accept
        vecs.push_back('{"fl0",    0, 16'h00FF, 0, 0, 1, 8'd7,  5'd8});
        vecs.push_back('{"fl1",    0, 16'h0100, 1, 1, 1, 8'd8,  5'd1});
        vecs.push_back('{"fl2",    0, 16'h0000, 1, 0, 0, 8'hF0, 5'd0});
        vecs.push_back('{"idlrdy", 0, 16'h0000, 0, 1, 0, 8'hF0, 5'd0});
        // low bits
        vecs.push_back('{"lo0",    0, 16'h0003, 0, 0, 1, 8'd1,  5'd2});
        vecs.push_back('{"lo1",    0, 16'h0000, 0, 1, 1, 8'd0,  5'd1});
        vecs.push_back('{"lo2",    0, 16'h0000, 0, 1, 0, 8'hF0, 5'd0});
        // reset beats flush and req_in
        vecs.push_back('{"rr0",    0, 16'hFFFF, 0, 0, 1, 8'd15, 5'd16});
        vecs.push_back('{"rr1",    1, 16'hFFFF, 1, 1, 0, 8'hF0, 5'd0});
        vecs.push_back('{"rr2",    0, 16'h0000, 0, 0, 0, 8'hF0, 5'd0});

        rr_mode = 1'b0;
        step(1'b1, 16'h0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].flush, vecs[i].ready);
            chk_out(vecs[i].name, vecs[i].exp_v, vecs[i].exp_code, vecs[i].exp_cnt);
        end

        // Round-robin: ptr is 0 after the reset above. Hold 8001 with ready.
        rr_mode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] e;
`ifdef PRIO_ENC_RR_EN
            e = (c % 2 == 0) ? 8'd15 : 8'd0;
`else
            e = 8'd15;
`endif
            step(1'b0, 16'h8001, 1'b0, 1'b1);
            chk_out($sformatf("rr%0d", c), 1'b1, e, 5'd2);
        end

        // Fixed mode with the same traffic: bit 15 every cycle.
        rr_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 16'h8001, 1'b0, 1'b1);
            chk_out($sformatf("fx%0d", c), 1'b1, 8'd15, 5'd2);
        end

        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk_out("endflush", 1'b0, 8'hF0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_enc_queue.md
Name: prio_enc_queue

Overview:
- Parametrised, registered successor to the team's 16-input combinational priority encoder.
- Latches request bits into a sticky pending vector and presents one encoded index at a time on a valid/ready output.
- Clears each index when the consumer accepts it.
- Sits between the pad-level request inputs (ui_in/uio_in) and downstream logic that must service every request, not only the highest one.

Parameters:
- WIDTH, 16: number of request lines, 2..64.
- OUT_W, 8: width of out_code; must be ≥ $clog2(WIDTH).
- IDLE_CODE, 8'hF0: value driven on out_code when nothing is pending. Truncated/zero-extended to OUT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_in  in  WIDTH  request pulses/levels; bit i set ⇒ request i pending from next cycle
- flush  in  1  clear all pending requests
- rr_mode  in  1  0 = fixed priority (MSB highest), 1 = round-robin (only with macro, see below)
- out_valid  out  1  a pending request is presented
- out_ready  in  1  consumer accepts presented index this cycle
- out_code  out  OUT_W  encoded index of presented request, zero-extended; IDLE_CODE when !out_valid
- pend_cnt  out  $clog2(WIDTH+1)  population count of pending vector

Behaviour:
- State: pending[WIDTH-1:0], ptr[$clog2(WIDTH)-1:0]. Both are 0 after reset.
- Reset (rst=1 at edge): pending=0, ptr=0. Outputs the next cycle: out_valid=0, out_code=IDLE_CODE, pend_cnt=0. Reset overrides req_in and flush in the same cycle.
- Clock and reset are fixed: one clock, named clk; reset is synchronous and active-high, named rst.
- Pending update each edge: pending <= (pending & ~clr) | req_in.
  - clr = onehot(sel) when out_valid && out_ready, else 0.
  - Simultaneous clear and new request on the same bit: the request wins and the bit stays pending.
- flush=1: pending <= req_in. Requests arriving in the flush cycle are kept. flush also suppresses clr.
- Selection is combinational from the pending and ptr registers only, never from req_in.
  - Latency req_in → out_valid is exactly 1 cycle.
  - out_valid = |pending.
  - Fixed mode: sel = highest set index of pending.
  - Round-robin mode: the search starts at index start = (ptr==0) ? WIDTH-1 : ptr-1, descends, and wraps from 0 to WIDTH-1. sel = first set bit found.
- ptr update: on accept (out_valid && out_ready), ptr <= sel, in either mode. The update is ignored on flush.
- out_code and out_valid are stable while out_valid && !out_ready, unless a new higher-priority request arrives. Pre-emption by a higher request is permitted; consumers must sample on the accept cycle only.
- pend_cnt = popcount(pending). It is registered-state derived, so it is zero-latency relative to pending.
- A mode change takes effect on the next selection (combinational). ptr is not reset by a mode change.
- out_ready while !out_valid: no effect.

Optional Feature:
- Macro: PRIO_ENC_RR_EN.
- Defined: rr_mode is honoured and round-robin selection is available as described above.
- Undefined:
  - rr_mode is ignored (tie-off allowed, no lint warning).
  - Selection is always fixed priority.
  - ptr logic is not synthesised.
  - Port list is unchanged in both builds.

Test Plan:
- Reset: drive req_in=16'hFFFF with rst=1 for 2 cycles. Required: out_valid=0, out_code=8'hF0, pend_cnt=0 throughout. On the cycle after rst falls: out_valid=1, out_code=15, pend_cnt=16.
- Fixed drain: req_in=16'h8421 for one cycle, out_ready=1. Required: out_code sequence 15, 10, 5, 0 on consecutive cycles, pend_cnt 4, 3, 2, 1, then out_valid=0 with out_code=8'hF0.
- Back-pressure and pre-emption: pending=bit 3, out_ready=0 for 3 cycles. Required: out_code=3 held. Then pulse req_in bit 12. Required: out_code=12 next cycle; pend_cnt=2.
- Clear/set collision: pending=bit 7 with accept, and req_in bit 7 in the same cycle. Required: bit 7 still pending; out_code=7 next cycle; pend_cnt unchanged at 1.
- Flush: pending=16'h00FF, flush=1 with req_in=16'h0100. Required: next cycle pend_cnt=1, out_code=8.
- Round-robin (PRIO_ENC_RR_EN, rr_mode=1): hold req_in=16'h8001 continuously with out_ready=1. Required: out_code alternates 15, 0, 15, 0. In fixed mode, or without the macro, it is 15 every cycle.
